neuron_mac_seq: RTL and testbench
=================================

Name: neuron_mac_seq

Overview:
Parametrised successor to the per-node fully-connected neuron; the node count is no longer fixed at ten, and the 8-bit wrap-around sum is removed.
- Computes one neuron per accepted vector: ReLU(requant(BIAS + sum x[i]*w[i])).
- Uses a single time-multiplexed multiplier with a wide accumulator, saturating requantisation and a valid/ready handshake on both sides.
- Sits between layer activation buffers and the next layer's input registers.

Parameters:
NUM_IN, 10, number of inputs/weights per neuron (>=1)
D_W, 8, signed activation width (input and output)
W_W, 8, signed weight width
ACC_W, 20, accumulator width; must be >= D_W+W_W+clog2(NUM_IN+1)
SHIFT, 4, arithmetic right shift applied to the accumulator before clamping (0..ACC_W-1)
WEIGHTS, 0, packed NUM_IN*W_W signed weights; w[i] = WEIGHTS[i*W_W +: W_W]
BIAS, 0, signed ACC_W bias, added at accumulator scale

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  NUM_IN*D_W  signed activations; x[i] = in_data[i*D_W +: D_W]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  D_W  activation result, range 0..2^(D_W-1)-1
busy  out  1  high in MAC or OUT

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, out_valid=0, out_data=0, in_ready=1, busy=0, acc=0, idx=0, captured inputs=0.
- States: IDLE, MAC, OUT.
- IDLE: in_ready=1. On in_valid, capture in_data into an internal register, set acc<=BIAS and idx<=0, then go to MAC.
- MAC: in_ready=0. Each cycle: acc <= acc + sext(x[idx]*w[idx]) and idx++. The product is full D_W+W_W signed precision, with no truncation.
  - On the cycle idx==NUM_IN-1, also register out_data <= requant(final acc), set out_valid<=1 and go to OUT.
- OUT: out_valid=1, and out_data is held stable until the handshake. When out_ready=1, clear out_valid and go to IDLE.
  - No new vector is accepted in the same cycle as the handshake; throughput is one vector per NUM_IN+2 cycles minimum.
- Latency: the handshake in cycle 0 gives out_valid high from cycle NUM_IN+1.
- requant(a):
  - q = a >>> SHIFT (arithmetic).
  - If q<0, result is 0 (ReLU).
  - Else if q > 2^(D_W-1)-1, result is 2^(D_W-1)-1 (saturate).
  - Else result is q[D_W-1:0].
- Accumulator overflow is impossible by the ACC_W constraint; an elaboration-time check fails if it is violated.
- in_data changing after the capture has no effect on the result.
- out_ready held high while in IDLE/MAC has no effect.
- Reset asserted mid-MAC or in OUT aborts the computation immediately; the result is discarded and out_valid drops asynchronously.
- NUM_IN=1: MAC lasts exactly one cycle.

Optional Feature:
Macro NEURON_ROUND_EN.
- Defined: requant adds 2^(SHIFT-1) before the shift (round half up) when SHIFT>0. The add is saturation-safe because an extra accumulator guard bit is used inside requant.
- Undefined: plain truncating arithmetic shift (floor).
- The ReLU and clamp rules are identical in both builds.

Decomposition:
- Package neuron_pkg: state enum (IDLE/MAC/OUT), clog2 constant function, ACC_W check helper.
- One sub-module, neuron_requant: purely combinational shift/round/ReLU/saturate, parametrised by ACC_W, D_W and SHIFT. It is instantiated once and reusable by future layer nodes.
- The FSM, index counter, input capture register and MAC live in neuron_mac_seq.

Test Plan:
- Common setup: NUM_IN=4, all weights 1, BIAS=0, SHIFT=0, inputs 10,20,30,40.
  - Normal: out_data=100, out_valid rises exactly 5 cycles after the input handshake, and in_ready=0 throughout.
- ReLU: same setup with inputs -10,-20,-30,-40: out_data=0.
- Saturation: weights all 127, inputs all 127, BIAS=0: out_data=127. Weights all -128, inputs all -128: out_data=127.
- Backpressure: hold out_ready=0 for 3 cycles in OUT. out_data stays constant, out_valid stays 1, in_ready stays 0, and in_valid pulses are ignored. Release gives one transfer, then in_ready=1.
- Reset mid-MAC: assert reset at idx=2. out_valid=0 and busy=0 immediately, and a following vector produces a correct, independent result.
- Rounding (SHIFT=2, single weight 1, NUM_IN=1):
  - input 6 gives out_data 1 without the macro and 2 with NEURON_ROUND_EN.
  - input 5 gives 1 in both builds.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and elaboration helpers for the sequential neuron MAC nodes.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'(1) << i) < 33'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // True when the accumulator is wide enough that BIAS plus NUM_IN full products cannot overflow.
    function automatic bit acc_w_ok(input int unsigned acc_w, input int unsigned d_w,
                                    input int unsigned w_w, input int unsigned num_in);
        return acc_w >= d_w + w_w + clog2(num_in + 1);
    endfunction

endpackage

// File: rtl/neuron_requant.sv
// Combinational requantiser: arithmetic shift (optionally rounded), ReLU, then saturate.
// Build option: define NEURON_ROUND_EN for round-half-up before the shift.
module neuron_requant
    import neuron_pkg::*;
#(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned D_W   = 8,
    parameter int unsigned SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [D_W-1:0]   result_c
);

    // One guard bit keeps the rounding add from wrapping at the top of the range.
    localparam int unsigned G_W     = ACC_W + 1;
    localparam int unsigned RND_SH  = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [G_W-1:0] MAX_POS = G_W'((1 << (D_W - 1)) - 1);
    localparam logic        [D_W-1:0] MAX_OUT = D_W'((1 << (D_W - 1)) - 1);

    logic signed [G_W-1:0] ext;
    logic signed [G_W-1:0] shifted;

    always_comb begin
        ext = G_W'(acc);
`ifdef NEURON_ROUND_EN
        if (SHIFT > 0) begin
            ext = ext + (G_W'(1) <<< RND_SH);
        end
`endif
        shifted = ext >>> SHIFT;
        if (shifted[G_W-1]) begin
            result_c = '0;
        end else if (shifted > MAX_POS) begin
            result_c = MAX_OUT;
        end else begin
            result_c = shifted[D_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// One neuron per accepted vector via a single time-multiplexed multiplier:
// ReLU(requant(BIAS + sum x[i]*w[i])). Build option NEURON_ROUND_EN selects rounding in requant.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int unsigned NUM_IN = 10,
    parameter int unsigned D_W    = 8,
    parameter int unsigned W_W    = 8,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned SHIFT  = 4,
    parameter logic        [NUM_IN*W_W-1:0] WEIGHTS = '0,
    parameter logic signed [ACC_W-1:0]      BIAS    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*D_W-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [D_W-1:0]          out_data,
    output logic                    busy
);

    localparam int unsigned P_W   = D_W + W_W;
    localparam int unsigned IDX_W = (NUM_IN > 1) ? clog2(NUM_IN) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_IN - 1);

    if (!acc_w_ok(ACC_W, D_W, W_W, NUM_IN)) begin : g_bad_acc_w
        $error("neuron_mac_seq: ACC_W too narrow for NUM_IN products of D_W x W_W");
    end

    state_t                   state;
    logic [NUM_IN*D_W-1:0]    x_reg;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [D_W-1:0]    x_cur;
    logic signed [W_W-1:0]    w_cur;
    logic signed [P_W-1:0]    prod;
    logic        [D_W-1:0]    rq_c;

    // Current operand pair and the full-precision running sum.
    always_comb begin
        x_cur    = x_reg[int'(idx)*D_W +: D_W];
        w_cur    = WEIGHTS[int'(idx)*W_W +: W_W];
        prod     = P_W'(x_cur) * P_W'(w_cur);
        acc_next = acc + ACC_W'(prod);
    end

    neuron_requant #(
        .ACC_W (ACC_W),
        .D_W   (D_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc      (acc_next),
        .result_c (rq_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            x_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg    <= in_data;
                        acc      <= BIAS;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    idx <= idx + IDX_W'(1);
                    // Last product: requantise the completed sum directly.
                    if (idx == LAST) begin
                        out_data  <= rq_c;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomised self-checking bench for neuron_mac_seq against an arithmetic reference model.
module tb_neuron_mac_seq;

    localparam logic [31:0] WTS   [4] = '{32'h01010101, 32'h7F7F7F7F, 32'h80808080, 32'h8064F903};
    localparam longint      BIASV [4] = '{0, 0, 0, -50};
    localparam int          SHV   [4] = '{0, 0, 0, 3};

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        rdy [4];
    logic        ov  [4];
    logic [7:0]  od  [4];
    logic        bz  [4];

    logic        v1_in_valid;
    logic        v1_in_ready;
    logic [7:0]  v1_in_data;
    logic        v1_out_valid;
    logic        v1_out_ready;
    logic [7:0]  v1_out_data;
    logic        v1_busy;

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    neuron_mac_seq #(.NUM_IN(4), .SHIFT(0), .WEIGHTS(32'h01010101), .BIAS(20'sd0)) u_ones (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));
    neuron_mac_seq #(.NUM_IN(4), .SHIFT(0), .WEIGHTS(32'h7F7F7F7F), .BIAS(20'sd0)) u_pos (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));
    neuron_mac_seq #(.NUM_IN(4), .SHIFT(0), .WEIGHTS(32'h80808080), .BIAS(20'sd0)) u_neg (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));
    neuron_mac_seq #(.NUM_IN(4), .SHIFT(3), .WEIGHTS(32'h8064F903), .BIAS(-20'sd50)) u_mix (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
        .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .busy(bz[3]));
    neuron_mac_seq #(.NUM_IN(1), .SHIFT(2), .WEIGHTS(8'h01), .BIAS(20'sd0)) u_one (
        .clk(clk), .reset(reset), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .in_data(v1_in_data), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
        .out_data(v1_out_data), .busy(v1_busy));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ReLU(requant(bias + dot product)) with plain integer arithmetic.
    function automatic longint model(input logic [31:0] data, input logic [31:0] w,
                                     input int n, input longint bias, input int sh);
        longint a;
        a = bias;
        for (int i = 0; i < n; i++) begin
            a += longint'($signed(data[i*8 +: 8])) * longint'($signed(w[i*8 +: 8]));
        end
`ifdef NEURON_ROUND_EN
        if (sh > 0) a += longint'(1) << (sh - 1);
`endif
        a = a >>> sh;
        if (a < 0) return 0;
        if (a > 127) return 127;
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_group(input string tag, input logic [31:0] data, input logic exp_v);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_valid_d%0d", tag, k), ov[k], exp_v);
            chk($sformatf("%s_data_d%0d", tag, k), od[k], model(data, WTS[k], 4, BIASV[k], SHV[k]));
        end
    endtask

    // One vector through the NUM_IN=4 group, holding off the result for 'hold' cycles.
    task automatic run_vec(input logic [31:0] data, input int hold);
        int cyc;
        in_data   = data;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk("in_ready_idle", rdy[0], 1);
        chk("busy_idle", bz[0], 0);
        step();
        in_valid = 1'b0;
        in_data  = $urandom();
        cyc = 1;
        while (ov[0] !== 1'b1 && cyc < 20) begin
            chk("in_ready_mac", rdy[0], 0);
            chk("busy_mac", bz[0], 1);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        chk("latency", cyc, 5);
        check_group("result", data, 1'b1);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = $urandom();
            step();
            check_group("hold", data, 1'b1);
            chk("in_ready_hold", rdy[0], 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_after_xfer", ov[0], 0);
        chk("in_ready_after_xfer", rdy[0], 1);
        chk("busy_after_xfer", bz[0], 0);
    endtask

    // Start a vector, then assert reset after 'n' clocks and check the abort.
    task automatic run_abort(input logic [31:0] data, input int n);
        in_data  = data;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
        if (n >= 4) chk("valid_before_abort", ov[3], 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_valid", ov[3], 0);
        chk("abort_busy", bz[3], 0);
        chk("abort_in_ready", rdy[3], 1);
        chk("abort_data", od[3], 0);
        step();
        reset = 1'b0;
    endtask

    task automatic run_one(input logic [7:0] x);
        int cyc;
        v1_in_data  = x;
        v1_in_valid = 1'b1;
        step();
        v1_in_valid = 1'b0;
        cyc = 1;
        while (v1_out_valid !== 1'b1 && cyc < 10) begin
            chk("n1_busy", v1_busy, 1);
            step();
            cyc++;
        end
        chk("n1_latency", cyc, 2);
        chk("n1_data", v1_out_data, model({24'b0, x}, 32'h00000001, 1, 0, 2));
        v1_out_ready = 1'b1;
        step();
        v1_out_ready = 1'b0;
        chk("n1_in_ready", v1_in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        v1_in_valid  = 1'b0;
        v1_in_data   = '0;
        v1_out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", ov[0], 0);
        chk("rst_out_data", od[0], 0);
        chk("rst_in_ready", rdy[0], 1);
        chk("rst_busy", bz[0], 0);
        chk("rst_n1_in_ready", v1_in_ready, 1);
        reset = 1'b0;
        step();

        run_vec(32'h281E140A, 0);
        chk("normal_100", od[0], 100);
        run_vec(32'hD8E2ECF6, 0);
        chk("relu_0", od[0], 0);
        run_vec(32'h7F7F7F7F, 3);
        chk("sat_pos", od[1], 127);
        run_vec(32'h80808080, 0);
        chk("sat_neg", od[2], 127);

        run_abort(32'h281E140A, 2);
        run_vec(32'h281E140A, 0);
        chk("after_abort", od[0], 100);
        run_abort($urandom(), 4);
        run_vec($urandom(), 1);

        for (int t = 0; t < 20; t++) begin
            run_vec($urandom(), $urandom_range(0, 2));
        end

        run_one(8'd6);
`ifdef NEURON_ROUND_EN
        chk("round_6", v1_out_data, 2);
`else
        chk("round_6", v1_out_data, 1);
`endif
        run_one(8'd5);
        chk("round_5", v1_out_data, 1);
        for (int t = 0; t < 10; t++) begin
            run_one(8'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
